branch_predictor: RTL
=====================

# branch_predictor

Parametrised branch predictor for the pipelined CPU fetch stage. It combines a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters. Fetch gets a same-cycle next-PC prediction. Execute writes back resolved outcomes one per cycle. Built-in statistics counters report update and mispredict totals to the bench. It replaces the fixed 2-bit, single-table predictor and adds the following:

- configurable table depth, counter width and tag width;
- tag checking;
- allocate-on-taken;
- statistics.

## Interface
Parameters:
- XLEN, 32: PC and target width.
- ENTRIES, 16: BTB entries; must be a power of two, at least 2. IDX_W = log2(ENTRIES).
- CTR_W, 2: direction counter width, at least 1.
- TAG_W, 8: stored tag width. Requires IDX_W+2+TAG_W ≤ XLEN.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- f_pc  in  XLEN  fetch PC for lookup.
- pred_hit  out  1  entry valid and tag matches.
- pred_taken  out  1  pred_hit and counter MSB = 1.
- pred_next_pc  out  XLEN  stored target if pred_taken, else f_pc+4 (mod 2^XLEN).
- upd_valid  in  1  resolved branch/jump update this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_taken  in  1  actual direction.
- upd_target  in  XLEN  actual taken target.
- upd_mispred  in  1  execute detected a misprediction; used only for statistics.
- stat_updates  out  32  count of accepted updates, saturating.
- stat_mispred  out  32  count of updates with upd_mispred = 1, saturating.

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+1+TAG_W:IDX_W+2]. pc[1:0] is ignored.
- Each entry holds: valid, tag[TAG_W], target[XLEN], ctr[CTR_W].
- Lookup is purely combinational on f_pc and current table state.
- When upd_valid = 1 and the entry at idx(upd_pc) is valid with a matching tag (hit):
  - upd_taken = 1: ctr = min(ctr+1, 2^CTR_W−1); target ← upd_target.
  - upd_taken = 0: ctr = max(ctr−1, 0); target is unchanged.
- When upd_valid = 1 and the entry misses:
  - upd_taken = 1: allocate. valid ← 1, tag ← tag(upd_pc), target ← upd_target, ctr ← 2^(CTR_W−1) (weakly taken). Any previous occupant is overwritten.
  - upd_taken = 0: no table change.
- Statistics, when upd_valid = 1:
  - stat_updates increments, holding at 0xFFFFFFFF.
  - stat_mispred increments if upd_mispred = 1, with the same saturation.
- Reset state:
  - All valid bits = 0.
  - All ctr = 2^(CTR_W−1)−1 (weakly not-taken; 0 when CTR_W = 1).
  - Targets and tags are don't-care.
  - Both statistics counters = 0.
- Reset assertion mid-operation clears state immediately, without waiting for a clock edge. An update presented during reset is discarded.

## Timing
- Lookup latency is 0 cycles: outputs settle combinationally from f_pc.
- Update latency is 1 cycle: the table write and statistics increment are visible to lookups after the rising edge that samples upd_valid = 1.
- Same-cycle lookup and update of the same index: lookup returns the pre-update state. There is no bypass.
- Outputs while reset is asserted and immediately after release: pred_hit = 0, pred_taken = 0, pred_next_pc = f_pc+4, stat_updates = 0, stat_mispred = 0.
- One update per cycle. There is no backpressure and no ready signal; every upd_valid cycle is consumed.
- The update path is single-port. Read-modify-write of ctr uses the registered value and completes within one cycle.
- Wrap-around: f_pc = 0xFFFFFFFC with no taken prediction gives pred_next_pc = 0x00000000.

## Test plan
- Reset: hold reset = 0 for 3 cycles with upd_valid = 1, then release. Expect stat_updates = 0, stat_mispred = 0, and for f_pc = 0x40: pred_hit = 0, pred_next_pc = 0x44.
- Allocate then predict, with defaults: update pc 0x40, taken, target 0x100. Next cycle f_pc = 0x40 gives pred_hit = 1, pred_taken = 1, pred_next_pc = 0x100. One not-taken update then makes ctr = 1 and pred_taken = 0, pred_next_pc = 0x44.
- Saturation: 5 taken updates on pc 0x40 hold ctr at 3. Exactly 2 not-taken updates are then needed to flip pred_taken to 0. A further 5 not-taken updates hold ctr at 0.
- Aliasing: allocate pc 0x40 (idx 0, tag 0x01). Lookup f_pc = 0x440 (idx 0, tag 0x11) gives pred_hit = 0. A not-taken update on 0x440 leaves entry 0x40 intact. A taken update on 0x440 to 0x200 evicts it, and 0x40 then misses.
- Same-cycle collision: with 0x40 allocated at ctr = 2, drive a lookup of 0x40 and a not-taken update of 0x40 in the same cycle. That cycle shows pred_taken = 1; the next cycle shows pred_taken = 0.
- Statistics and mid-run reset: 10 updates, 3 with upd_mispred = 1, give stat_updates = 10 and stat_mispred = 3. Asserting reset asynchronously between edges clears both counters and all hits before the next clock edge.

Source files
------------

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Direct-mapped BTB with per-entry saturating direction
//                counters, same-cycle fetch prediction, one resolved update
//                per cycle, and saturating update/mispredict statistics.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_predictor #(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 16,
   parameter int CTR_W   = 2,
   parameter int TAG_W   = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] f_pc,
   output logic            pred_hit,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_next_pc,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_mispred,
   output logic [31:0]     stat_updates,
   output logic [31:0]     stat_mispred
);

   localparam int c_idx_w = $clog2(ENTRIES);
   localparam int c_tag_lo = c_idx_w + 2;
   localparam int c_tag_hi = c_idx_w + 1 + TAG_W;
   localparam logic [CTR_W-1:0] c_ctr_max    = {CTR_W{1'b1}};
   localparam logic [CTR_W-1:0] c_ctr_weak_t = CTR_W'(1) << (CTR_W - 1);
   localparam logic [CTR_W-1:0] c_ctr_reset  = c_ctr_weak_t - CTR_W'(1);

   // Table state: valid/ctr are reset, tag/target are payload only
   logic               r_valid  [ENTRIES];
   logic [CTR_W-1:0]   r_ctr    [ENTRIES];
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [XLEN-1:0]    r_target [ENTRIES];
   logic [31:0]        r_stat_updates;
   logic [31:0]        r_stat_mispred;

   logic [c_idx_w-1:0] w_f_idx;
   logic [TAG_W-1:0]   w_f_tag;
   logic [c_idx_w-1:0] w_u_idx;
   logic [TAG_W-1:0]   w_u_tag;
   logic               w_u_hit;
   logic [CTR_W-1:0]   w_ctr_cur;
   logic [CTR_W-1:0]   w_ctr_inc;
   logic [CTR_W-1:0]   w_ctr_dec;
   logic               w_unused_f;
   logic               w_unused_u;

   assign w_f_idx = f_pc[c_idx_w+1:2];
   assign w_f_tag = f_pc[c_tag_hi:c_tag_lo];
   assign w_u_idx = upd_pc[c_idx_w+1:2];
   assign w_u_tag = upd_pc[c_tag_hi:c_tag_lo];

   // PC bits outside index/tag take no part in lookup or update
   generate
      if (c_tag_hi + 1 < XLEN) begin : g_pc_hi
         assign w_unused_f = ^{f_pc[XLEN-1:c_tag_hi+1], f_pc[1:0]};
         assign w_unused_u = ^{upd_pc[XLEN-1:c_tag_hi+1], upd_pc[1:0]};
      end else begin : g_pc_no_hi
         assign w_unused_f = ^f_pc[1:0];
         assign w_unused_u = ^upd_pc[1:0];
      end
   endgenerate

   // Fetch lookup: purely combinational, no bypass from the update port
   assign pred_hit     = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
   assign pred_taken   = pred_hit && r_ctr[w_f_idx][CTR_W-1];
   assign pred_next_pc = pred_taken ? r_target[w_f_idx] : f_pc + XLEN'(4);

   // Update-side hit and saturating counter step from the registered value
   assign w_u_hit   = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
   assign w_ctr_cur = r_ctr[w_u_idx];
   assign w_ctr_inc = (w_ctr_cur == c_ctr_max)  ? w_ctr_cur : w_ctr_cur + CTR_W'(1);
   assign w_ctr_dec = (w_ctr_cur == '0)         ? w_ctr_cur : w_ctr_cur - CTR_W'(1);

   // Valid bits and direction counters: train on hit, allocate on taken miss
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i] <= 1'b0;
            r_ctr[i]   <= c_ctr_reset;
         end
      end else if (upd_valid) begin
         if (w_u_hit) begin
            r_ctr[w_u_idx] <= upd_taken ? w_ctr_inc : w_ctr_dec;
         end else if (upd_taken) begin
            r_valid[w_u_idx] <= 1'b1;
            r_ctr[w_u_idx]   <= c_ctr_weak_t;
         end
      end
   end

   // Tag/target payload: every taken update either hits (same tag) or allocates
   always_ff @(posedge clk) begin
      if (upd_valid && upd_taken) begin
         r_tag[w_u_idx]    <= w_u_tag;
         r_target[w_u_idx] <= upd_target;
      end
   end

   // Saturating statistics counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stat_updates <= '0;
         r_stat_mispred <= '0;
      end else if (upd_valid) begin
         if (r_stat_updates != 32'hFFFF_FFFF)
            r_stat_updates <= r_stat_updates + 32'd1;
         if (upd_mispred && (r_stat_mispred != 32'hFFFF_FFFF))
            r_stat_mispred <= r_stat_mispred + 32'd1;
      end
   end

   assign stat_updates = r_stat_updates;
   assign stat_mispred = r_stat_mispred;

endmodule
`default_nettype wire
